// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline hazard logic.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       reg_write_m,
    input logic [4:0] rd_w,
    input logic       reg_write_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Freezes the pipeline while a MEM-stage access is unacknowledged;
// a watchdog releases the freeze after MEM_TIMEOUT cycles and latches mem_err.
module hazard_mem_fsm
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic mem_stall_o,
  output logic mem_err_o
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  hz_state_t     state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          pending;
  logic          timeout_hit;

  assign pending     = mem_req_i && !mem_ready_i;
  // Wait cycle k carries wait_cnt_q == k-1, so the release lands on cycle MEM_TIMEOUT.
  assign timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST) && pending;
  assign mem_stall_o = pending && !timeout_hit;
  assign mem_err_o   = mem_err_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q || timeout_hit;
    unique case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (mem_stall_o) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall_o) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall,
// branch flush, memory-wait freeze and saturating stall/flush counters.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rs1_e,
  input  logic [4:0]           rs2_e,
  input  logic [4:0]           rd_e,
  input  logic [1:0]           result_src_e,
  input  logic                 pc_src_e,
  input  logic [4:0]           rd_m,
  input  logic                 reg_write_m,
  input  logic [4:0]           rd_w,
  input  logic                 reg_write_w,
  input  logic                 mem_req_m,
  input  logic                 mem_ready,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_w,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  fwd_sel_t             fwd_a, fwd_b;
  logic                 lw_stall;
  logic                 mem_stall;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  assign fwd_a       = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign fwd_b       = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;

  assign lw_stall = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  hazard_mem_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_req_i  (mem_req_m),
    .mem_ready_i(mem_ready),
    .mem_stall_o(mem_stall),
    .mem_err_o  (mem_err)
  );

  // During a memory freeze EX is held, so branch/load-use actions simply replay later.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_d = pc_src_e;
      flush_e = lw_stall || pc_src_e;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if ((flush_d || flush_e) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic       pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  hazard_unit #(
    .MEM_TIMEOUT(4),
    .CNT_WIDTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .result_src_e(result_src_e),
    .pc_src_e    (pc_src_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .mem_req_m   (mem_req_m),
    .mem_ready   (mem_ready),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .stall_m     (stall_m),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_w     (flush_w),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0; result_src_e = '0; pc_src_e = 1'b0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    check("rst_fwd_a", forward_a_e, 2'b00);
    check("rst_fwd_b", forward_b_e, 2'b00);
    check("rst_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    check("rst_flushes", {flush_d, flush_e, flush_w}, 3'b000);
    check("rst_mem_err", mem_err, 1'b0);
    check("rst_stall_cnt", stall_cnt, 4'd0);
    check("rst_flush_cnt", flush_cnt, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Forwarding priorities
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
    rs2_e = 5'd3;
    #1;
    check("fwd_a_mem", forward_a_e, 2'b10);
    check("fwd_b_none", forward_b_e, 2'b00);
    reg_write_m = 1'b0;
    #1;
    check("fwd_a_wb", forward_a_e, 2'b01);
    rs2_e = 5'd5; rd_m = 5'd3; reg_write_m = 1'b1;
    #1;
    check("fwd_b_wb_other_mem", forward_b_e, 2'b01);
    rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    #1;
    check("fwd_a_x0", forward_a_e, 2'b00);
    idle();
    step();

    // Load-use, plus the rd_e==x0 exemption
    result_src_e = 2'b01; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    check("lw_x0_no_stall", stall_f, 1'b0);
    rd_e = 5'd7; rs2_d = 5'd7;
    #1;
    check("lw_stall_fd", {stall_f, stall_d}, 2'b11);
    check("lw_flush", {flush_d, flush_e, flush_w}, 3'b010);
    check("lw_stall_em", {stall_e, stall_m}, 2'b00);
    step();
    idle();
    #1;
    check("lw_one_cycle", stall_f, 1'b0);
    check("lw_stall_cnt", stall_cnt, 4'd1);
    check("lw_flush_cnt", flush_cnt, 4'd1);

    // Branch taken
    pc_src_e = 1'b1;
    #1;
    check("br_flush", {flush_d, flush_e}, 2'b11);
    check("br_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    step();
    idle();
    #1;
    check("br_flush_cnt", flush_cnt, 4'd2);

    // Branch and load-use together
    pc_src_e = 1'b1; result_src_e = 2'b01; rd_e = 5'd4; rs1_d = 5'd4;
    #1;
    check("br_lw_both", {stall_f, stall_d, flush_d, flush_e}, 4'b1111);
    step();
    idle();
    #1;
    check("br_lw_stall_cnt", stall_cnt, 4'd2);
    check("br_lw_flush_cnt", flush_cnt, 4'd3);

    // Memory wait of 3 cycles with a pending branch
    mem_req_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stall", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'b11111);
      check("mw_br_deferred", {flush_d, flush_e}, 2'b00);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("mw_ready_release", {stall_f, stall_m, flush_w}, 3'b000);
    check("mw_ready_br", {flush_d, flush_e}, 2'b11);
    step();
    idle();
    #1;
    check("mw_stall_cnt", stall_cnt, 4'd5);
    check("mw_flush_cnt", flush_cnt, 4'd4);
    check("mw_no_err", mem_err, 1'b0);

    // Watchdog timeout
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to_stall", stall_m, 1'b1);
      step();
    end
    #1;
    check("to_release", {stall_f, stall_m, flush_w}, 3'b000);
    check("to_err_not_yet", mem_err, 1'b0);
    step();
    idle();
    #1;
    check("to_err_set", mem_err, 1'b1);
    step();
    step();
    check("to_err_sticky", mem_err, 1'b1);
    check("to_stall_cnt", stall_cnt, 4'd8);

    // Reset in the middle of a wait
    mem_req_m = 1'b1; mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rw_err_clr", mem_err, 1'b0);
    check("rw_cnt_clr", stall_cnt, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_c1", stall_m, 1'b1);
    step();
    check("rw_c2", stall_m, 1'b1);
    step();
    check("rw_c3", stall_m, 1'b1);
    step();
    check("rw_c4_release", {stall_m, flush_w}, 2'b00);
    step();
    idle();
    #1;
    check("rw_err_again", mem_err, 1'b1);

    // Counter saturation
    rst = 1'b0;
    #1;
    check("sat_err_clr", mem_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
    for (int i = 0; i < 20; i++) step();
    check("sat_stall_cnt", stall_cnt, 4'd15);
    check("sat_flush_cnt", flush_cnt, 4'd15);
    idle();
    step();
    check("sat_hold", stall_cnt, 4'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
